// File: rtl/bcminer_pkg.sv
// Shared miner types: nonce width, nonce type and
// the end-of-search status states used by the result FIFO.
package bcminer_pkg;

   localparam int NONCE_W = 32;

   typedef logic [NONCE_W-1:0] nonce_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_DONE = 1'b1
   } search_state_e;

endpackage

// File: rtl/nonce_result_fifo_if.sv
// Nonce write / read handshake bundle between the miner,
// the result FIFO and the host reader.
interface nonce_result_fifo_if #(
   parameter int NONCE_W = bcminer_pkg::NONCE_W
);

   logic               wr_en;
   logic [NONCE_W-1:0] wr_nonce;
   logic               rd_ready;
   logic               rd_valid;
   logic [NONCE_W-1:0] rd_nonce;

   modport master (
      output wr_en,
      output wr_nonce,
      output rd_ready,
      input  rd_valid,
      input  rd_nonce
   );

   modport slave (
      input  wr_en,
      input  wr_nonce,
      input  rd_ready,
      output rd_valid,
      output rd_nonce
   );

endinterface

// File: rtl/nonce_result_fifo_mem.sv
// DEPTH x NONCE_W storage: one write port, asynchronous read.
// Cleared on flush so the head reads zero after reset.
module nonce_fifo_mem #(
   parameter int DEPTH   = 8,
   parameter int NONCE_W = 32,
   parameter int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               we,
   input  logic [AW-1:0]      waddr,
   input  logic [NONCE_W-1:0] wdata,
   input  logic [AW-1:0]      raddr,
   output logic [NONCE_W-1:0] rdata
);

   logic [NONCE_W-1:0] mem_q [DEPTH];
   logic [NONCE_W-1:0] mem_d [DEPTH];

   // Next array contents: flush, else single-entry write
   always_comb begin
      mem_d = mem_q;
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = '0;
         end
      end else if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Storage register
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/nonce_result_fifo.sv
// First-word-fall-through nonce FIFO behind the miner, with
// drop accounting and a latched end-of-search outcome.
module nonce_result_fifo
   import bcminer_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int NONCE_W = bcminer_pkg::NONCE_W,
   parameter int DROP_W  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   nonce_result_fifo_if.slave     bus,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   overflow,
   output logic [DROP_W-1:0]      drop_count,
   input  logic                   result_valid,
   input  logic                   success,
   output logic                   search_done,
   output logic                   search_found,
   output logic                   drained
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_count_q, drop_count_d;
   search_state_e     state_q, state_d;
   logic              found_q, found_d;
   logic              drained_q, drained_d;

   logic              empty;
   logic              pop;
   logic              push;
   logic              drop;
   logic [PW-1:0]     count_d;

   // Occupancy flags from the extra-MSB pointer pair
   always_comb begin
      empty = (wr_ptr_q == rd_ptr_q);
      full  = (wr_ptr_q[AW] != rd_ptr_q[AW])
           && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop   = !empty && bus.rd_ready;
      push  = bus.wr_en && (!full || pop);
      drop  = bus.wr_en && full && !pop;
   end

   // Next-state for pointers, drop tracking and search status
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
      state_d      = state_q;
      found_d      = found_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      if (drop) begin
         overflow_d = 1'b1;
         if (drop_count_q != '1) begin
            drop_count_d = drop_count_q + 1'b1;
         end
      end

      if (state_q == S_IDLE && result_valid) begin
         state_d = S_DONE;
         found_d = success;
      end

      // A flush wins over every same-cycle event
      if (clear) begin
         wr_ptr_d     = '0;
         rd_ptr_d     = '0;
         overflow_d   = 1'b0;
         drop_count_d = '0;
         state_d      = S_IDLE;
         found_d      = 1'b0;
      end

      count_d   = wr_ptr_d - rd_ptr_d;
      drained_d = (state_d == S_DONE) && (count_d == '0);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
         state_q      <= S_IDLE;
         found_q      <= 1'b0;
         drained_q    <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
         state_q      <= state_d;
         found_q      <= found_d;
         drained_q    <= drained_d;
      end
   end

   nonce_fifo_mem #(
      .DEPTH   (DEPTH),
      .NONCE_W (NONCE_W),
      .AW      (AW)
   ) u_mem (
      .clk   (clk),
      .clr   (rst || clear),
      .we    (push && !clear),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (bus.wr_nonce),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (bus.rd_nonce)
   );

   assign bus.rd_valid  = !empty;
   assign count         = wr_ptr_q - rd_ptr_q;
   assign overflow      = overflow_q;
   assign drop_count    = drop_count_q;
   assign search_done   = (state_q == S_DONE);
   assign search_found  = found_q;
   assign drained       = drained_q;

endmodule

// File: tb/tb_nonce_result_fifo.sv
// Directed bench for nonce_result_fifo (DEPTH=8, NONCE_W=32, DROP_W=8).
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_nonce_result_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       clear;
   logic [3:0] count;
   logic       full;
   logic       overflow;
   logic [7:0] drop_count;
   logic       result_valid;
   logic       success;
   logic       search_done;
   logic       search_found;
   logic       drained;

   int checks = 0;
   int errors = 0;

   nonce_result_fifo_if #(.NONCE_W(32)) bus ();

   nonce_result_fifo #(
      .DEPTH   (8),
      .NONCE_W (32),
      .DROP_W  (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .bus          (bus),
      .count        (count),
      .full         (full),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .result_valid (result_valid),
      .success      (success),
      .search_done  (search_done),
      .search_found (search_found),
      .drained      (drained)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] v);
      bus.wr_en    = 1'b1;
      bus.wr_nonce = v;
      tick();
      bus.wr_en    = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   logic [31:0] exp_t1 [3];

   initial begin
      rst          = 1'b1;
      clear        = 1'b0;
      bus.wr_en    = 1'b0;
      bus.wr_nonce = '0;
      bus.rd_ready = 1'b0;
      result_valid = 1'b0;
      success      = 1'b0;
      exp_t1[0] = 32'hA1;
      exp_t1[1] = 32'hB2;
      exp_t1[2] = 32'hC3;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_count", 32'(count), 0);
      chk("rst_valid", 32'(bus.rd_valid), 0);
      chk("rst_nonce", bus.rd_nonce, 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_drop", 32'(drop_count), 0);
      chk("rst_done", 32'(search_done), 0);
      chk("rst_found", 32'(search_found), 0);
      chk("rst_drained", 32'(drained), 0);

      // 1: three pushes, then three reads
      push(32'hA1);
      chk("t1_valid1", 32'(bus.rd_valid), 1);
      chk("t1_head1", bus.rd_nonce, 32'hA1);
      push(32'hB2);
      push(32'hC3);
      chk("t1_count3", 32'(count), 3);
      chk("t1_head3", bus.rd_nonce, 32'hA1);
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t1_rd", bus.rd_nonce, exp_t1[i]);
         tick();
      end
      bus.rd_ready = 1'b0;
      chk("t1_count0", 32'(count), 0);
      chk("t1_valid0", 32'(bus.rd_valid), 0);

      // 2: ten pushes into eight slots
      for (int i = 0; i < 10; i++) begin
         push(32'h100 + 32'(i));
         if (i == 7) chk("t2_full8", 32'(full), 1);
         if (i == 7) chk("t2_ovf8", 32'(overflow), 0);
      end
      chk("t2_count", 32'(count), 8);
      chk("t2_ovf", 32'(overflow), 1);
      chk("t2_drop", 32'(drop_count), 2);
      bus.rd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t2_rd", bus.rd_nonce, 32'h100 + 32'(i));
         tick();
      end
      bus.rd_ready = 1'b0;
      chk("t2_empty", 32'(count), 0);
      chk("t2_ovf_sticky", 32'(overflow), 1);
      do_clear();
      chk("t2_clr_ovf", 32'(overflow), 0);

      // 3: write into a full FIFO with a same-cycle pop
      for (int i = 0; i < 8; i++) push(32'h200 + 32'(i));
      chk("t3_full", 32'(full), 1);
      bus.wr_en    = 1'b1;
      bus.wr_nonce = 32'h2FF;
      bus.rd_ready = 1'b1;
      tick();
      bus.wr_en    = 1'b0;
      bus.rd_ready = 1'b0;
      chk("t3_count", 32'(count), 8);
      chk("t3_full2", 32'(full), 1);
      chk("t3_ovf", 32'(overflow), 0);
      chk("t3_drop", 32'(drop_count), 0);
      chk("t3_head", bus.rd_nonce, 32'h201);
      bus.rd_ready = 1'b1;
      for (int i = 1; i < 8; i++) begin
         chk("t3_rd", bus.rd_nonce, 32'h200 + 32'(i));
         tick();
      end
      chk("t3_rd_last", bus.rd_nonce, 32'h2FF);
      tick();
      bus.rd_ready = 1'b0;
      chk("t3_empty", 32'(count), 0);

      // 4: outcome latch and drained timing
      do_clear();
      push(32'h31);
      push(32'h32);
      result_valid = 1'b1;
      success      = 1'b1;
      tick();
      chk("t4_done", 32'(search_done), 1);
      chk("t4_found", 32'(search_found), 1);
      chk("t4_drn0", 32'(drained), 0);
      success = 1'b0;
      tick();
      result_valid = 1'b0;
      chk("t4_found2", 32'(search_found), 1);
      chk("t4_done2", 32'(search_done), 1);
      bus.rd_ready = 1'b1;
      tick();
      chk("t4_cnt1", 32'(count), 1);
      chk("t4_drn1", 32'(drained), 0);
      tick();
      bus.rd_ready = 1'b0;
      chk("t4_cnt0", 32'(count), 0);
      chk("t4_drn2", 32'(drained), 1);
      tick();
      chk("t4_drn3", 32'(drained), 1);

      // 5: clear mid-stream with a write pending
      do_clear();
      for (int i = 0; i < 9; i++) push(32'h50 + 32'(i));
      bus.rd_ready = 1'b1;
      tick();
      tick();
      tick();
      bus.rd_ready = 1'b0;
      result_valid = 1'b1;
      success      = 1'b1;
      tick();
      result_valid = 1'b0;
      chk("t5_pre_cnt", 32'(count), 5);
      chk("t5_pre_ovf", 32'(overflow), 1);
      chk("t5_pre_done", 32'(search_done), 1);
      clear        = 1'b1;
      bus.wr_en    = 1'b1;
      bus.wr_nonce = 32'hEE;
      tick();
      clear     = 1'b0;
      bus.wr_en = 1'b0;
      chk("t5_cnt", 32'(count), 0);
      chk("t5_valid", 32'(bus.rd_valid), 0);
      chk("t5_ovf", 32'(overflow), 0);
      chk("t5_drop", 32'(drop_count), 0);
      chk("t5_done", 32'(search_done), 0);
      chk("t5_found", 32'(search_found), 0);
      chk("t5_drn", 32'(drained), 0);
      tick();
      chk("t5_cnt_hold", 32'(count), 0);

      // 6: drop counter saturation
      for (int i = 0; i < 8; i++) push(32'h600 + 32'(i));
      bus.wr_en    = 1'b1;
      bus.wr_nonce = 32'h6FF;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 253) chk("t6_drop254", 32'(drop_count), 254);
      end
      bus.wr_en = 1'b0;
      chk("t6_drop_sat", 32'(drop_count), 255);
      chk("t6_ovf", 32'(overflow), 1);
      chk("t6_count", 32'(count), 8);
      chk("t6_head", bus.rd_nonce, 32'h600);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
